ctrl_unit_mc: RTL
=================

CTRL_UNIT_MC -- requirements
Module: ctrl_unit_mc

Interface
REQ-001 SHALL have parameter DATALINES, default 16: RAM word and instruction width.
REQ-002 SHALL have parameter ADLINES, default 8: RAM address and PC width.
REQ-003 SHALL have parameter OPSIZE, default 4: opcode width.
REQ-004 SHALL have parameter ALUWIDTH, default 8: ALU operand width.
REQ-005 SHALL have parameter RESET_PC, default 1: PC after reset.
REQ-006 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-007 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, 1 bit: run request.
REQ-009 SHALL have port ram_addr, output, ADLINES bits: RAM address.
REQ-010 SHALL have ports ram_rd and ram_wr, outputs, 1 bit each: read and write strobes.
REQ-011 SHALL have port ram_wdata, output, DATALINES bits: write data.
REQ-012 SHALL have ports ram_rdata, input, DATALINES bits, and ram_ready, input, 1 bit: read data and access-complete.
REQ-013 SHALL have ports alu_op, output, OPSIZE bits; alu_a and alu_b, outputs, ALUWIDTH bits; alu_y, input, ALUWIDTH bits.
REQ-014 SHALL have ports pc, output, ADLINES bits, and halted, output, 1 bit.

Function
REQ-015 SHALL decode each instruction as: opcode = top OPSIZE bits; field A = next FW bits; field B = low FW bits, where FW = (DATALINES-OPSIZE)/2; fields zero-extended or truncated to ADLINES.
REQ-016 SHALL implement states IDLE, FETCH, DECODE, RDA, RDB, EXEC, WRA, HALT.
REQ-017 SHALL transition IDLE->FETCH when enable=1; pc unchanged.
REQ-018 SHALL perform each memory access by holding ram_addr/ram_rd (or ram_wr/ram_wdata) stable until a rising edge with ram_ready=1, capture ram_rdata at that edge, and deassert the strobe next cycle; ram_rd and ram_wr never both 1.
REQ-019 SHALL, in FETCH, read mem[pc] into the instruction register, then go to DECODE.
REQ-020 SHALL, for opcode 0 (HALT), go DECODE->HALT; halted=1; remain in HALT until reset.
REQ-021 SHALL, for opcode all-ones (JMP), load pc <= field A in DECODE and go to FETCH (or IDLE per REQ-025); no data access.
REQ-022 SHALL, for any other opcode: RDA reads mem[A]; RDB reads mem[B]; EXEC drives alu_op=opcode, alu_a/alu_b = low ALUWIDTH bits of the captured words, and registers alu_y; WRA writes alu_y zero-extended to DATALINES into mem[A]; pc <= pc+1 on WRA completion.
REQ-023 SHALL achieve latency with ram_ready tied 1: ALU instruction 6 cycles, JMP 2, HALT 2 to halted=1.
REQ-024 SHALL wrap pc from 2^ADLINES-1 to 0 on increment.
REQ-025 SHALL, if enable falls mid-instruction, complete that instruction and enter IDLE at the boundary with pc pointing to the next instruction; enable is sampled only at instruction boundaries.
REQ-026 SHALL hold alu_op, alu_a and alu_b at 0 outside EXEC.

Reset
REQ-027 SHALL, on rst_n=0 (asynchronously, including mid-access), force state=IDLE, pc=RESET_PC, ram_rd=ram_wr=0, ram_addr=0, ram_wdata=0, alu outputs 0, halted=0, and clear instruction and data registers.
REQ-028 SHALL resume at the first rising clk edge after rst_n returns to 1.

Structure
REQ-029 SHALL place the state encoding, the opcode constants HALT=0 and JMP=all-ones, and the default widths in the shared parameters package used by ALU and RAM blocks.
REQ-030 SHALL consist of a single module; the memory-access handshake MAY be factored into sub-module ram_port_ctl.

Verification
REQ-031 SHALL verify: mem[16]=5, mem[17]=2, mem[1]=ADD(16,17), mem[2]=HALT, ram_ready=1, enable=1 -> mem[16]=7, halted=1, pc=2, ALU instruction completes in 6 cycles.
REQ-032 SHALL verify: same program with ram_ready asserted every 3rd cycle -> same final memory; strobes stable while ram_ready=0.
REQ-033 SHALL verify: mem[1]=JMP 5, mem[5]=HALT -> pc=5 two cycles after the JMP fetch completes; halted=1.
REQ-034 SHALL verify: enable dropped during RDB -> WRA completes, IDLE with pc=2; re-asserting enable resumes at 2.
REQ-035 SHALL verify: rst_n pulsed low during WRA -> ram_wr=0 immediately, pc=1, state IDLE.
REQ-036 SHALL verify: ADLINES=4, pc=15, ALU instruction -> pc wraps to 0.

Source files
------------

// File: rtl/ctrl_unit_mc_pkg.sv
// Shared definitions for the multi-cycle control unit and the ALU/RAM blocks
// around it: default widths, FSM state encoding and the reserved opcodes.
package ctrl_unit_mc_pkg;

  localparam int DEF_DATALINES = 16;
  localparam int DEF_ADLINES   = 8;
  localparam int DEF_OPSIZE    = 4;
  localparam int DEF_ALUWIDTH  = 8;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_RDA    = 3'd3,
    S_RDB    = 3'd4,
    S_EXEC   = 3'd5,
    S_WRA    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  // Opcode 0 stops the machine; the all-ones opcode is an unconditional jump.
  localparam logic [DEF_OPSIZE-1:0] OP_HALT = '0;
  localparam logic [DEF_OPSIZE-1:0] OP_JMP  = '1;

endpackage

// File: rtl/ctrl_unit_mc.sv
// Multi-cycle control unit: fetches an instruction, reads two operands, runs
// them through an external ALU and writes the result back over one RAM port.
module ctrl_unit_mc
  import ctrl_unit_mc_pkg::*;
#(
  parameter int DATALINES = DEF_DATALINES,
  parameter int ADLINES   = DEF_ADLINES,
  parameter int OPSIZE    = DEF_OPSIZE,
  parameter int ALUWIDTH  = DEF_ALUWIDTH,
  parameter int RESET_PC  = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 enable,
  output logic [ADLINES-1:0]   ram_addr,
  output logic                 ram_rd,
  output logic                 ram_wr,
  output logic [DATALINES-1:0] ram_wdata,
  input  logic [DATALINES-1:0] ram_rdata,
  input  logic                 ram_ready,
  output logic [OPSIZE-1:0]    alu_op,
  output logic [ALUWIDTH-1:0]  alu_a,
  output logic [ALUWIDTH-1:0]  alu_b,
  input  logic [ALUWIDTH-1:0]  alu_y,
  output logic [ADLINES-1:0]   pc,
  output logic                 halted,
  output state_t               dbg_state
);

  localparam int FW = (DATALINES - OPSIZE) / 2;
  localparam logic [ADLINES-1:0] PC_RST   = ADLINES'(RESET_PC);
  localparam logic [OPSIZE-1:0]  OPC_HALT = OPSIZE'(OP_HALT);
  localparam logic [OPSIZE-1:0]  OPC_JMP  = {OPSIZE{1'b1}};

  state_t                state;
  logic [DATALINES-1:0]  ir;
  logic [ALUWIDTH-1:0]   da;
  logic [OPSIZE-1:0]     opcode;
  logic [ADLINES-1:0]    fa;
  logic [ADLINES-1:0]    fb;
  logic [ADLINES-1:0]    pc_inc;

  assign opcode    = ir[DATALINES-1 -: OPSIZE];
  assign fa        = ADLINES'(ir[DATALINES-OPSIZE-1 -: FW]);
  assign fb        = ADLINES'(ir[FW-1:0]);
  assign pc_inc    = pc + 1'b1;
  assign dbg_state = state;

  // RAM handshake: a request (ram_rd or ram_wr with ram_addr/ram_wdata) is
  // held unchanged until a rising edge sees ram_ready=1; that edge completes
  // the access, captures ram_rdata, and the strobe drops (or moves on to the
  // next access) in the following cycle. ram_rd and ram_wr are never both 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= PC_RST;
      ram_addr  <= '0;
      ram_rd    <= 1'b0;
      ram_wr    <= 1'b0;
      ram_wdata <= '0;
      alu_op    <= '0;
      alu_a     <= '0;
      alu_b     <= '0;
      halted    <= 1'b0;
      ir        <= '0;
      da        <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (enable) begin
            state    <= S_FETCH;
            ram_rd   <= 1'b1;
            ram_addr <= pc;
          end
        end
        S_FETCH: begin
          if (ram_ready) begin
            ir     <= ram_rdata;
            ram_rd <= 1'b0;
            state  <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (opcode == OPC_HALT) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (opcode == OPC_JMP) begin
            pc <= fa;
            // Instruction boundary: enable decides whether to keep running.
            if (enable) begin
              state    <= S_FETCH;
              ram_rd   <= 1'b1;
              ram_addr <= fa;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            state    <= S_RDA;
            ram_rd   <= 1'b1;
            ram_addr <= fa;
          end
        end
        S_RDA: begin
          if (ram_ready) begin
            da       <= ram_rdata[ALUWIDTH-1:0];
            ram_addr <= fb;
            state    <= S_RDB;
          end
        end
        S_RDB: begin
          if (ram_ready) begin
            ram_rd <= 1'b0;
            alu_op <= opcode;
            alu_a  <= da;
            alu_b  <= ram_rdata[ALUWIDTH-1:0];
            state  <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_op    <= '0;
          alu_a     <= '0;
          alu_b     <= '0;
          ram_wr    <= 1'b1;
          ram_addr  <= fa;
          ram_wdata <= DATALINES'(alu_y);
          state     <= S_WRA;
        end
        S_WRA: begin
          if (ram_ready) begin
            ram_wr <= 1'b0;
            pc     <= pc_inc;
            if (enable) begin
              state    <= S_FETCH;
              ram_rd   <= 1'b1;
              ram_addr <= pc_inc;
            end else begin
              state <= S_IDLE;
            end
          end
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
